dispatch_stage: RTL and testbench

- Sits between rename and the reservation station.
- Accepts one renamed rs_issue_packet_t per cycle over a valid/ready handshake and holds it in a one-entry pipeline register.
- Tracks which physical registers have in-flight producers in a busy-bit table. From that table it drives the RS write port together with the src1/src2 "already ready" flags.
- Clears busy bits by snooping the CDB.

---
 rtl/dispatch_stage_pkg.sv | 21 ++
 rtl/dispatch_stage_if.sv | 23 ++
 rtl/dispatch_stage_busy_table.sv | 26 ++
 rtl/dispatch_stage.sv | 50 +++++
 tb/tb_dispatch_stage.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/dispatch_stage_pkg.sv
// pipeline_types: shared rename/dispatch packet types and physical-tag constants
package pipeline_types;
  localparam int PHYS_TAG_W = 6;
  localparam int ROB_TAG_W = 5;
  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  localparam phys_tag_t P_ZERO = '0;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;
  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          imm;
    alu_op_t              alu_op;
    logic                 alu_src;
    phys_tag_t            rs1_p;
    phys_tag_t            rs2_p;
    phys_tag_t            rd_p;
    logic [ROB_TAG_W-1:0] rob_tag;
  } rs_issue_packet_t;
endpackage

// File: rtl/dispatch_stage_if.sv
// dispatch_stage_if: rename-side handshake, RS write port, CDB snoop and stall counter
interface dispatch_stage_if import pipeline_types::*; #(parameter int CNT_W = 32);
  logic             in_valid;
  logic             in_ready;
  rs_issue_packet_t in_packet;
  logic             in_rd_write;
  logic             rs_full;
  logic             rs_write_en;
  rs_issue_packet_t rs_write_data;
  logic             rs_src1_ready;
  logic             rs_src2_ready;
  logic             cdb_valid;
  phys_tag_t        cdb_tag;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output in_valid, in_packet, in_rd_write, rs_full, cdb_valid, cdb_tag,
    input  in_ready, rs_write_en, rs_write_data, rs_src1_ready, rs_src2_ready, stall_cycles
  );
  modport slave (
    input  in_valid, in_packet, in_rd_write, rs_full, cdb_valid, cdb_tag,
    output in_ready, rs_write_en, rs_write_data, rs_src1_ready, rs_src2_ready, stall_cycles
  );
endinterface

// File: rtl/dispatch_stage_busy_table.sv
// busy_table: physical-register busy bits with one set port, one clear port and CDB-bypassed reads
module busy_table import pipeline_types::*; #(
  parameter int N_PHYS = 64
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  phys_tag_t set_tag,
  input  logic      clr_en,
  input  phys_tag_t clr_tag,
  input  phys_tag_t rd1_tag,
  input  phys_tag_t rd2_tag,
  output logic      rd1_ready,
  output logic      rd2_ready
);
  logic [N_PHYS-1:0] busy, busy_n;
  always_comb begin
    busy_n = '0;
    for (int i = 1; i < N_PHYS; i++)
      busy_n[i] = (set_en && set_tag == phys_tag_t'(i)) ? 1'b1 :
                  (clr_en && clr_tag == phys_tag_t'(i)) ? 1'b0 : busy[i];
  end
  always_ff @(posedge clk) busy <= reset ? busy_n : '0;
  assign rd1_ready = !busy[rd1_tag] || (clr_en && clr_tag == rd1_tag);
  assign rd2_ready = !busy[rd2_tag] || (clr_en && clr_tag == rd2_tag);
endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: one-entry rename-to-RS pipeline register with busy-table operand readiness
module dispatch_stage import pipeline_types::*; #(
  parameter int N_PHYS = 64,
  parameter int CNT_W  = 32
) (
  input logic             clk,
  input logic             reset,
  dispatch_stage_if.slave bus
);
  logic             buf_valid;
  logic             buf_rd_write;
  rs_issue_packet_t buf_pkt;
  logic [CNT_W-1:0] stall_cnt;
  logic             rs_fire, accept, src1, src2;
  assign rs_fire           = reset && buf_valid && !bus.rs_full;
  assign bus.in_ready      = reset && (!buf_valid || rs_fire);
  assign accept            = bus.in_valid && bus.in_ready;
  assign bus.rs_write_en   = rs_fire;
  assign bus.rs_write_data = buf_pkt;
  assign bus.rs_src1_ready = !reset || src1;
  assign bus.rs_src2_ready = !reset || buf_pkt.alu_src || src2;
  assign bus.stall_cycles  = stall_cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      buf_valid <= accept || (buf_valid && !rs_fire);
      if (buf_valid && bus.rs_full && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_pkt      <= bus.in_packet;
      buf_rd_write <= bus.in_rd_write;
    end
  end
  busy_table #(.N_PHYS(N_PHYS)) u_busy (
    .clk       (clk),
    .reset     (reset),
    .set_en    (rs_fire && buf_rd_write),
    .set_tag   (buf_pkt.rd_p),
    .clr_en    (bus.cdb_valid),
    .clr_tag   (bus.cdb_tag),
    .rd1_tag   (buf_pkt.rs1_p),
    .rd2_tag   (buf_pkt.rs2_p),
    .rd1_ready (src1),
    .rd2_ready (src2)
  );
endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed plus random stimulus against a queue/array reference model
module tb_dispatch_stage;
  import pipeline_types::*;
  typedef struct {
    rs_issue_packet_t p;
    logic             w;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  ent_t q[$];
  logic [63:0] mbusy = '0;
  logic [31:0] mstall = '0;
  logic obs_ir, obs_we, obs_s1, obs_s2;
  rs_issue_packet_t p1, p2;
  dispatch_stage_if #(.CNT_W(32)) bus ();
  dispatch_stage #(.N_PHYS(64), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic rs_issue_packet_t mk(input phys_tag_t a, input phys_tag_t b, input phys_tag_t d, input logic imm);
    mk.pc      = $urandom;
    mk.imm     = $urandom;
    mk.alu_op  = alu_op_t'($urandom_range(0, 9));
    mk.alu_src = imm;
    mk.rs1_p   = a;
    mk.rs2_p   = b;
    mk.rd_p    = d;
    mk.rob_tag = 5'($urandom_range(0, 31));
  endfunction
  function automatic phys_tag_t rt();
    return phys_tag_t'($urandom_range(0, 15));
  endfunction
  task automatic step(input logic v, input rs_issue_packet_t p, input logic w, input logic full,
                      input logic cv, input phys_tag_t ct);
    logic eir, ewe;
    ent_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_packet = p;
    bus.in_rd_write = w;
    bus.rs_full = full;
    bus.cdb_valid = cv;
    bus.cdb_tag = ct;
    #1;
    eir = reset && (q.size() == 0 || !full);
    ewe = reset && q.size() != 0 && !full;
    obs_ir = bus.in_ready;
    obs_we = bus.rs_write_en;
    obs_s1 = bus.rs_src1_ready;
    obs_s2 = bus.rs_src2_ready;
    check("in_ready", obs_ir, eir);
    check("rs_write_en", obs_we, ewe);
    check("stall_cycles", bus.stall_cycles, mstall);
    check("busy_table", dut.u_busy.busy, mbusy);
    if (ewe) begin
      check("rs_write_data", bus.rs_write_data, q[0].p);
      check("src1_ready", obs_s1, !mbusy[q[0].p.rs1_p] || (cv && ct == q[0].p.rs1_p));
      check("src2_ready", obs_s2, q[0].p.alu_src || !mbusy[q[0].p.rs2_p] || (cv && ct == q[0].p.rs2_p));
    end
    if (!reset) begin
      check("reset_src1", obs_s1, 1'b1);
      check("reset_src2", obs_s2, 1'b1);
    end
    @(posedge clk);
    if (!reset) begin
      mbusy = '0;
      q.delete();
      mstall = '0;
    end else begin
      if (q.size() != 0 && full && mstall != 32'hffff_ffff) mstall++;
      if (ewe) e = q.pop_front();
      if (cv) mbusy[ct] = 1'b0;
      if (ewe && e.w && e.p.rd_p != P_ZERO) mbusy[e.p.rd_p] = 1'b1;
      if (v && eir) q.push_back('{p, w});
    end
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_packet = '0;
    bus.in_rd_write = 1'b0;
    bus.rs_full = 1'b0;
    bus.cdb_valid = 1'b0;
    bus.cdb_tag = '0;
    idle(2);
    check("reset_in_ready", obs_ir, 1'b0);
    reset = 1'b1;
    step(1'b1, mk(3, 4, 10, 0), 1'b1, 1'b0, 1'b0, 0);
    check("first_in_ready", obs_ir, 1'b1);
    idle(1);
    check("t1_we", obs_we, 1'b1);
    check("t1_src1", obs_s1, 1'b1);
    check("t1_src2", obs_s2, 1'b1);
    check("t1_busy10", dut.u_busy.busy[10], 1'b1);
    step(1'b1, mk(0, 0, 20, 0), 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, mk(20, 0, 0, 0), 1'b0, 1'b0, 1'b0, 0);
    idle(1);
    check("b2b_src1", obs_s1, 1'b0);
    step(1'b1, mk(0, 0, 21, 0), 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, mk(21, 0, 0, 0), 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 21);
    check("b2b_cdb_src1", obs_s1, 1'b1);
    check("b2b_cdb_busy21", dut.u_busy.busy[21], 1'b0);
    step(1'b1, mk(0, 10, 0, 1), 1'b0, 1'b0, 1'b0, 0);
    idle(1);
    check("imm_src2", obs_s2, 1'b1);
    step(1'b1, mk(0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 0);
    idle(1);
    check("p0_busy", dut.u_busy.busy[0], 1'b0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    p1 = mk(1, 2, 30, 0);
    p2 = mk(30, 3, 31, 0);
    step(1'b1, p1, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, p2, 1'b1, 1'b1, 1'b0, 0);
      check("stall_we", obs_we, 1'b0);
      check("stall_in_ready", obs_ir, 1'b0);
      check("stall_data", bus.rs_write_data, p1);
    end
    check("stall_count5", bus.stall_cycles, 32'd5);
    step(1'b1, p2, 1'b1, 1'b0, 1'b0, 0);
    check("release_we", obs_we, 1'b1);
    check("release_in_ready", obs_ir, 1'b1);
    idle(1);
    check("release_next_we", obs_we, 1'b1);
    check("release_src1", obs_s1, 1'b0);
    step(1'b1, mk(0, 0, 12, 0), 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 12);
    check("set_wins_busy12", dut.u_busy.busy[12], 1'b1);
    step(1'b1, mk(0, 0, 5, 0), 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 0);
    check("pre_rst_stall", bus.stall_cycles, 32'd8);
    check("pre_rst_busy5", dut.u_busy.busy[5], 1'b1);
    reset = 1'b0;
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 0);
    check("rst_we", obs_we, 1'b0);
    check("rst_buf_valid", dut.buf_valid, 1'b0);
    check("rst_busy", dut.u_busy.busy, 64'd0);
    check("rst_stall", bus.stall_cycles, 32'd0);
    reset = 1'b1;
    idle(1);
    check("post_rst_in_ready", obs_ir, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) < 7, mk(rt(), rt(), rt(), $urandom_range(0, 3) == 0),
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), rt());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
